// File: rtl/wave_pkg.sv
// wave_pkg: shared types and helpers for the per-wave status file
package wave_pkg;
  localparam int MAX_WAVES = 16;
  localparam int MAX_PC_W = 64;
  typedef struct packed {
    logic                scc;
    logic [MAX_PC_W-1:0] pc;
    logic                active;
    logic                barrier;
    logic                clause;
  } wave_status_t;
  function automatic logic wave_idx_valid(input int unsigned idx, input int unsigned n);
    return idx < n;
  endfunction
endpackage

// File: rtl/wave_status_file_if.sv
// wave_status_file_if: read/write/advance bus between scheduler, execute and the status file
interface wave_status_file_if #(
  parameter int NUM_WAVES = 4,
  parameter int PC_WIDTH = 48,
  parameter int WID_W = (NUM_WAVES > 1) ? $clog2(NUM_WAVES) : 1
);
  logic [WID_W-1:0]     rd_wave;
  logic                 scc;
  logic [PC_WIDTH-1:0]  pc;
  logic                 active;
  logic                 barrier;
  logic                 clause;
  logic [WID_W-1:0]     wr_wave;
  logic                 scc_data, scc_we;
  logic [PC_WIDTH-1:0]  pc_data;
  logic                 pc_we;
  logic                 active_data, active_we;
  logic                 barrier_data, barrier_we;
  logic                 clause_data, clause_we;
  logic                 adv_valid;
  logic [WID_W-1:0]     adv_wave;
  logic [NUM_WAVES-1:0] active_mask;
  logic [NUM_WAVES-1:0] barrier_mask;
  logic                 barrier_release;
  modport slave (
    input  rd_wave, wr_wave, scc_data, scc_we, pc_data, pc_we, active_data, active_we,
           barrier_data, barrier_we, clause_data, clause_we, adv_valid, adv_wave,
    output scc, pc, active, barrier, clause, active_mask, barrier_mask, barrier_release
  );
  modport master (
    output rd_wave, wr_wave, scc_data, scc_we, pc_data, pc_we, active_data, active_we,
           barrier_data, barrier_we, clause_data, clause_we, adv_valid, adv_wave,
    input  scc, pc, active, barrier, clause, active_mask, barrier_mask, barrier_release
  );
endinterface

// File: rtl/barrier_sync.sv
// barrier_sync: detects every active wave waiting and issues the clear and release pulse
module barrier_sync #(
  parameter int NUM_WAVES = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_WAVES-1:0] i_active_mask,
  input  logic [NUM_WAVES-1:0] i_barrier_mask,
  output logic                 o_release_clear,
  output logic                 o_barrier_release
);
  logic r_release;
  assign o_release_clear = |i_active_mask && ((i_barrier_mask & i_active_mask) == i_active_mask);
  assign o_barrier_release = r_release;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_release <= 1'b0;
    else r_release <= o_release_clear;
endmodule

// File: rtl/wave_status_file.sv
// wave_status_file: per-wavefront SCC/PC/active/barrier/clause state with bypassed read,
// write port, PC advance port and workgroup barrier release
module wave_status_file import wave_pkg::*; #(
  parameter int NUM_WAVES = 4,
  parameter int PC_WIDTH = 48,
  parameter int PC_STEP = 4,
  parameter int WID_W = (NUM_WAVES > 1) ? $clog2(NUM_WAVES) : 1
) (
  input logic clk,
  input logic reset_n,
  wave_status_file_if.slave bus
);
  wave_status_t         w_st [NUM_WAVES];
  logic [NUM_WAVES-1:0] w_active, w_barrier;
  logic                 w_clear;
  for (genvar w = 0; w < NUM_WAVES; w++) begin : g_slot
    wave_status_t r_st;
    logic         w_hit, w_adv;
    assign w_hit = bus.wr_wave == WID_W'(w);
    assign w_adv = bus.adv_valid && bus.adv_wave == WID_W'(w);
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) r_st <= '0;
      else begin
        r_st.scc <= w_hit && bus.scc_we ? bus.scc_data : r_st.scc;
        r_st.active <= w_hit && bus.active_we ? bus.active_data : r_st.active;
        r_st.clause <= w_hit && bus.clause_we ? bus.clause_data : r_st.clause;
        r_st.barrier <= w_hit && bus.barrier_we ? bus.barrier_data : w_clear ? 1'b0 : r_st.barrier;
        r_st.pc <= w_hit && bus.pc_we ? MAX_PC_W'(bus.pc_data) :
                   w_adv ? MAX_PC_W'(r_st.pc[PC_WIDTH-1:0] + PC_WIDTH'(PC_STEP)) : r_st.pc;
      end
    assign w_st[w] = r_st;
    assign w_active[w] = r_st.active;
    assign w_barrier[w] = r_st.barrier;
  end
  barrier_sync #(.NUM_WAVES(NUM_WAVES)) u_barrier_sync (
    .clk              (clk),
    .reset_n          (reset_n),
    .i_active_mask    (w_active),
    .i_barrier_mask   (w_barrier),
    .o_release_clear  (w_clear),
    .o_barrier_release(bus.barrier_release)
  );
  wave_status_t        w_sel, w_rd;
  logic                w_rd_ok, w_byp;
  logic [MAX_PC_W-1:0] w_unused_pc;
  assign w_rd_ok = wave_idx_valid(32'(bus.rd_wave), NUM_WAVES);
  assign w_sel = w_rd_ok ? w_st[bus.rd_wave] : '0;
  assign w_byp = w_rd_ok && bus.wr_wave == bus.rd_wave;
  // each field bypasses independently; the advance port never bypasses
  always_comb begin
    w_rd = w_sel;
    w_rd.scc = w_byp && bus.scc_we ? bus.scc_data : w_sel.scc;
    w_rd.pc = w_byp && bus.pc_we ? MAX_PC_W'(bus.pc_data) : w_sel.pc;
    w_rd.active = w_byp && bus.active_we ? bus.active_data : w_sel.active;
    w_rd.barrier = w_byp && bus.barrier_we ? bus.barrier_data : w_sel.barrier;
    w_rd.clause = w_byp && bus.clause_we ? bus.clause_data : w_sel.clause;
  end
  assign w_unused_pc = w_rd.pc;
  assign bus.scc = w_rd.scc;
  assign bus.pc = w_rd.pc[PC_WIDTH-1:0];
  assign bus.active = w_rd.active;
  assign bus.barrier = w_rd.barrier;
  assign bus.clause = w_rd.clause;
  assign bus.active_mask = w_active;
  assign bus.barrier_mask = w_barrier;
endmodule

// File: tb/tb_wave_status_file.sv
// tb_wave_status_file: directed scoreboard bench for the wave status file
module tb_wave_status_file;
  logic clk, reset_n;
  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  string tag_q[$];
  wave_status_file_if #(.NUM_WAVES(4), .PC_WIDTH(48)) bus();
  wave_status_file #(.NUM_WAVES(4), .PC_WIDTH(48), .PC_STEP(4)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1);
  end
  task automatic push(input string t, input logic [63:0] v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask
  task automatic chk(input logic [63:0] obs);
    string t;
    logic [63:0] e;
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", t, obs, e);
    end
  endtask
  task automatic idle();
    bus.scc_we = 0; bus.pc_we = 0; bus.active_we = 0; bus.barrier_we = 0; bus.clause_we = 0;
    bus.adv_valid = 0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_barrier(input int w);
    bus.wr_wave = 2'(w); bus.barrier_we = 1; bus.barrier_data = 1;
    tick(); idle();
  endtask
  initial begin
    reset_n = 0;
    idle();
    bus.rd_wave = 0; bus.wr_wave = 0; bus.adv_wave = 0;
    bus.scc_data = 0; bus.pc_data = '0; bus.active_data = 0; bus.barrier_data = 0; bus.clause_data = 0;
    repeat (2) tick();
    push("rst_pc", 0); chk(64'(bus.pc));
    push("rst_scc", 0); chk(64'(bus.scc));
    push("rst_active_mask", 0); chk(64'(bus.active_mask));
    push("rst_release", 0); chk(64'(bus.barrier_release));
    reset_n = 1;
    tick();
    bus.rd_wave = 2; bus.wr_wave = 2; bus.pc_we = 1; bus.pc_data = 48'h100; bus.scc_we = 1; bus.scc_data = 1;
    push("byp_pc", 64'h100); push("byp_scc", 1);
    #1; chk(64'(bus.pc)); chk(64'(bus.scc));
    tick(); idle();
    push("held_pc", 64'h100); push("held_scc", 1);
    #1; chk(64'(bus.pc)); chk(64'(bus.scc));
    bus.rd_wave = 1; bus.wr_wave = 2; bus.clause_we = 1; bus.clause_data = 1;
    push("other_wave_pc", 0); push("other_wave_clause", 0);
    #1; chk(64'(bus.pc)); chk(64'(bus.clause));
    tick(); idle();
    bus.wr_wave = 1; bus.pc_we = 1; bus.pc_data = 48'h200;
    tick(); idle();
    bus.adv_valid = 1; bus.adv_wave = 1;
    push("adv_no_bypass", 64'h200);
    #1; chk(64'(bus.pc));
    tick(); idle();
    push("adv_pc", 64'h204);
    #1; chk(64'(bus.pc));
    bus.wr_wave = 1; bus.pc_we = 1; bus.pc_data = 48'h10; bus.adv_valid = 1; bus.adv_wave = 1;
    push("load_vs_adv_byp", 64'h10);
    #1; chk(64'(bus.pc));
    tick(); idle();
    push("load_beats_adv", 64'h10);
    #1; chk(64'(bus.pc));
    bus.pc_we = 1; bus.pc_data = 48'hFFFF_FFFF_FFFC;
    tick(); idle();
    bus.adv_valid = 1; bus.adv_wave = 1;
    tick(); idle();
    push("adv_wrap", 0);
    #1; chk(64'(bus.pc));
    for (int i = 0; i < 3; i++) begin
      bus.wr_wave = 2'(i); bus.active_we = 1; bus.active_data = 1;
      tick(); idle();
    end
    push("active_mask_012", 4'b0111);
    #1; chk(64'(bus.active_mask));
    for (int i = 0; i < 3; i++) set_barrier(i);
    bus.rd_wave = 2;
    push("barrier_mask_full", 4'b0111); push("no_early_release", 0); push("rd_barrier", 1);
    #1; chk(64'(bus.barrier_mask)); chk(64'(bus.barrier_release)); chk(64'(bus.barrier));
    tick();
    push("release_pulse", 1); push("barrier_cleared", 0);
    chk(64'(bus.barrier_release)); chk(64'(bus.barrier_mask));
    tick();
    push("release_one_cycle", 0);
    chk(64'(bus.barrier_release));
    for (int i = 0; i < 3; i++) set_barrier(i);
    set_barrier(0);
    push("rearrive_release", 1); push("rearrive_mask", 4'b0001);
    chk(64'(bus.barrier_release)); chk(64'(bus.barrier_mask));
    tick();
    push("rearrive_no_release", 0);
    chk(64'(bus.barrier_release));
    bus.wr_wave = 2; bus.active_we = 1; bus.active_data = 0;
    tick(); idle();
    push("deact2_mask", 4'b0011); push("deact2_no_release", 0);
    #1; chk(64'(bus.active_mask)); chk(64'(bus.barrier_release));
    bus.wr_wave = 1; bus.active_we = 1; bus.active_data = 0;
    tick(); idle();
    push("deact1_mask", 4'b0001); push("deact1_no_release_yet", 0); push("deact1_barrier", 4'b0001);
    #1; chk(64'(bus.active_mask)); chk(64'(bus.barrier_release)); chk(64'(bus.barrier_mask));
    tick();
    push("deact_release", 1); push("deact_cleared", 0);
    chk(64'(bus.barrier_release)); chk(64'(bus.barrier_mask));
    tick();
    push("deact_release_end", 0);
    chk(64'(bus.barrier_release));
    bus.wr_wave = 0; bus.active_we = 1; bus.active_data = 0;
    tick(); idle();
    set_barrier(0);
    tick();
    push("none_active_mask", 0); push("none_barrier", 4'b0001); push("none_no_release", 0);
    chk(64'(bus.active_mask)); chk(64'(bus.barrier_mask)); chk(64'(bus.barrier_release));
    bus.wr_wave = 0; bus.active_we = 1; bus.active_data = 1;
    tick(); idle();
    tick();
    bus.rd_wave = 2;
    push("pending_release", 1); push("pre_reset_pc", 64'h100);
    #1; chk(64'(bus.barrier_release)); chk(64'(bus.pc));
    #2;
    reset_n = 0;
    #1;
    push("async_rst_release", 0); push("async_rst_active", 0); push("async_rst_barrier", 0); push("async_rst_pc", 0);
    chk(64'(bus.barrier_release)); chk(64'(bus.active_mask)); chk(64'(bus.barrier_mask)); chk(64'(bus.pc));
    tick();
    reset_n = 1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wave_status_file.md
Name: wave_status_file

Overview:
- Per-wavefront status register file and the multi-wavefront successor of the single-wave status register.
- Holds SCC, PC, active, barrier-wait and clause bits for NUM_WAVES wavefronts.
- Provides one bypassed read port, one write port and one PC-advance port.
- Adds workgroup barrier release: when every active wave waits on the barrier, all barrier bits clear and a release pulse is emitted.
- Sits between the wave scheduler/issue stage and the scalar execute unit.

Parameters:
- NUM_WAVES, 4, number of wavefront contexts (1..16).
- PC_WIDTH, 48, program counter width in bits.
- PC_STEP, 4, PC increment applied on advance.
- WID_W, $clog2(NUM_WAVES) (minimum 1), wave index width.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- rd_wave  in  WID_W  wave selected for read
- scc  out  1  SCC of rd_wave (bypassed)
- pc  out  PC_WIDTH  PC of rd_wave (bypassed)
- active  out  1  active bit of rd_wave (bypassed)
- barrier  out  1  barrier-wait bit of rd_wave (bypassed)
- clause  out  1  clause bit of rd_wave (bypassed)
- wr_wave  in  WID_W  wave targeted by the write port
- scc_data, scc_we  in  1, 1  SCC write
- pc_data, pc_we  in  PC_WIDTH, 1  PC write
- active_data, active_we  in  1, 1  active write
- barrier_data, barrier_we  in  1, 1  barrier write
- clause_data, clause_we  in  1, 1  clause write
- adv_valid  in  1  advance PC of adv_wave by PC_STEP
- adv_wave  in  WID_W  wave whose PC advances
- active_mask  out  NUM_WAVES  registered active bits, all waves
- barrier_mask  out  NUM_WAVES  registered barrier bits, all waves
- barrier_release  out  1  one-cycle pulse, barrier released

Behaviour:
- Reset (async assert, sync deassert from the reset synchroniser): all per-wave fields 0, barrier_release 0. All outputs therefore read 0.
- Read is combinational from rd_wave.
  - Each field independently bypasses: if X_we and wr_wave==rd_wave, output X_data; otherwise output the stored value.
  - pc does NOT bypass the advance port. The advance is visible the next cycle.
- Writes take effect at the next posedge, per field, for wr_wave only.
- PC update per wave w, in priority order:
  - pc_we && wr_wave==w: load pc_data.
  - else adv_valid && adv_wave==w: pc + PC_STEP, modulo 2^PC_WIDTH (wraps; e.g. max-3 with step 4 gives 0).
  - else hold.
  - Unlike the previous generation, there is no free-running increment.
- Out-of-range wave index (>= NUM_WAVES): writes and advances are ignored; reads return 0.
- Barrier release:
  - all_wait = (active_mask != 0) && ((barrier_mask & active_mask) == active_mask). Evaluated on registered state only.
  - When all_wait=1 at an edge: every barrier bit clears, and barrier_release is 1 for the following cycle.
  - A barrier_we in the same cycle overrides the clear for wr_wave only (a wave re-arriving at the next barrier).
  - barrier_release is registered and deasserts after one cycle unless all_wait holds again.
- Barrier bits of inactive waves are ignored for all_wait but retained.
- Clearing active on the last non-waiting wave makes all_wait true on the next cycle, which triggers release.
- No active waves: all_wait=0, no release.
- Reset asserted mid-operation: immediate clear, including a pending release pulse.

Decomposition:
- Shared package wave_pkg:
  - MAX_WAVES constant.
  - wave_status_t struct {scc, pc, active, barrier, clause}.
  - function wave_idx_valid().
- Sub-module barrier_sync:
  - Inputs: active_mask, barrier_mask.
  - Output: release_clear pulse and barrier_release register.
  - The top-level generate loop instantiates one status slot per wave.

Test Plan:
- Reset: pulse reset_n low mid-cycle -> all outputs 0 immediately; active_mask=0, barrier_release=0.
- Write bypass: rd_wave=2, wr_wave=2, pc_we=1, pc_data=0x100 -> pc=0x100 same cycle; next cycle with pc_we=0 -> pc=0x100.
- Advance vs load, wave 1 at 0x200:
  - adv_valid, adv_wave=1 -> 0x204 next cycle.
  - pc_we=1, pc_data=0x10 together with adv -> 0x10.
  - PC at 0xFFFF_FFFF_FFFC plus advance -> 0.
- Barrier release:
  - Waves 0..2 active; set barrier on 0, 1, 2 on successive cycles.
  - One cycle after wave 2's write, barrier_release=1 for exactly one cycle and barrier_mask=0.
  - Wave 3 (inactive) does not block release.
- Same-cycle barrier write during release clear: wr_wave=0, barrier_we=1 in the release-clear cycle -> barrier_mask=0001 afterwards.
- Deactivate waiter: waves 0, 1 active, wave 0 waiting; active_we clears wave 1 -> release pulse the following cycle.
